// File: rtl/tte_hash_pkg.sv
// Shared definitions for the TTE flow hash table write-port controller.
//   HASH_W    : table address width
//   FLOW_W    : flow key width
//   TBL_DEPTH : number of table entries (2**HASH_W)
//   state_e   : controller FSM states
//   wdata_t   : table write word {valid, flow}
package tte_hash_pkg;

  localparam int HASH_W    = 10;
  localparam int FLOW_W    = 120;
  localparam int TBL_DEPTH = 1 << HASH_W;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    CLEAR = 2'd2
  } state_e;

  typedef struct packed {
    logic              valid;
    logic [FLOW_W-1:0] flow;
  } wdata_t;

  // Encoding of last_grant: index of the requester that won most recently.
  localparam logic GNT_BUS = 1'b0;
  localparam logic GNT_LRN = 1'b1;

endpackage

// File: rtl/tte_hash_ctrl_if.sv
// Bus, learn and table-port signals of the hash table write controller.
//   slave  : the controller (consumes bus/learn requests, drives the table port)
//   master : the environment (register-bus front end, learner, table RAM side)
interface tte_hash_ctrl_if;
  import tte_hash_pkg::*;

  logic              bus_update;
  logic [FLOW_W-1:0] bus_flow;
  logic [HASH_W-1:0] bus_hash;
  logic              bus_clear;
  logic              lrn_req;
  logic [FLOW_W-1:0] lrn_flow;
  logic [HASH_W-1:0] lrn_hash;
  logic              lrn_ack;
  logic              tbl_we;
  logic [HASH_W-1:0] tbl_addr;
  wdata_t            tbl_wdata;
  logic              busy;
  logic              clear_done;
  logic [7:0]        drop_cnt;

  modport slave (
    input  bus_update, bus_flow, bus_hash, bus_clear, lrn_req, lrn_flow, lrn_hash,
    output lrn_ack, tbl_we, tbl_addr, tbl_wdata, busy, clear_done, drop_cnt
  );

  modport master (
    output bus_update, bus_flow, bus_hash, bus_clear, lrn_req, lrn_flow, lrn_hash,
    input  lrn_ack, tbl_we, tbl_addr, tbl_wdata, busy, clear_done, drop_cnt
  );

endinterface

// File: rtl/tte_hash_ctrl_rr_arb2.sv
// Two-requester round-robin arbiter (purely combinational).
//   req_i        : [0] bus update pending, [1] learn request
//   last_grant_i : index of the previous winner
//   enable_i     : grants are only issued while high
//   grant_o      : one-hot grant
//   last_grant_o : winner index to store; unchanged when nothing is granted
module tte_rr_arb2
  import tte_hash_pkg::*;
(
  input  logic [1:0] req_i,
  input  logic       last_grant_i,
  input  logic       enable_i,
  output logic [1:0] grant_o,
  output logic       last_grant_o
);

  // NOTE: every output of a combinational block gets a default first so no
  // path leaves it unassigned, which would infer a latch.
  always_comb begin
    grant_o      = 2'b00;
    last_grant_o = last_grant_i;
    if (enable_i) begin
      unique case (req_i)
        2'b01:   grant_o = 2'b01;
        2'b10:   grant_o = 2'b10;
        // Contention: the requester that did not win last time goes now.
        2'b11:   grant_o = (last_grant_i == GNT_LRN) ? 2'b01 : 2'b10;
        default: grant_o = 2'b00;
      endcase
    end
    if (grant_o[1])      last_grant_o = GNT_LRN;
    else if (grant_o[0]) last_grant_o = GNT_BUS;
  end

endmodule

// File: rtl/tte_hash_ctrl.sv
// Write-port controller for the TTE flow hash table. Serialises bus updates,
// learn writes and full-table clear sweeps onto the single table write port.
//   clk, rstn : clock, asynchronous active-low reset
//   hif       : bus update/clear pulses, learn req/ack, table write port,
//               busy, clear_done and saturating drop counter
module tte_hash_ctrl
  import tte_hash_pkg::*;
(
  input  logic           clk,
  input  logic           rstn,
  tte_hash_ctrl_if.slave hif
);

  state_e            state_q, state_d;
  logic              bus_pend_q, bus_pend_d;
  logic [FLOW_W-1:0] bus_flow_q, bus_flow_d;
  logic [HASH_W-1:0] bus_hash_q, bus_hash_d;
  logic              clr_pend_q, clr_pend_d;
  logic              last_grant_q, last_grant_d;
  logic              lrn_ack_q, lrn_ack_d;
  logic              tbl_we_q, tbl_we_d;
  logic [HASH_W-1:0] tbl_addr_q, tbl_addr_d;
  wdata_t            tbl_wdata_q, tbl_wdata_d;
  logic              clear_done_q, clear_done_d;
  logic [7:0]        drop_cnt_q, drop_cnt_d;

  logic [1:0]        grant;
  logic              clr_take;
  logic              sweep_end;

  // A pending clear pre-empts arbitration; grant[0] = bus, grant[1] = learn.
  assign clr_take  = (state_q == IDLE) && clr_pend_q;
  assign sweep_end = (state_q == CLEAR) && (tbl_addr_q == HASH_W'(TBL_DEPTH - 1));

  tte_rr_arb2 u_arb (
    .req_i        ({hif.lrn_req, bus_pend_q}),
    .last_grant_i (last_grant_q),
    .enable_i     ((state_q == IDLE) && !clr_pend_q),
    .grant_o      (grant),
    .last_grant_o (last_grant_d)
  );

  // State and control registers.
  // NOTE: sequential state is assigned with non-blocking (<=) so every
  // register samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q      <= IDLE;
      bus_pend_q   <= 1'b0;
      clr_pend_q   <= 1'b0;
      last_grant_q <= GNT_BUS;
      lrn_ack_q    <= 1'b0;
      tbl_we_q     <= 1'b0;
      tbl_addr_q   <= '0;
      tbl_wdata_q  <= '0;
      clear_done_q <= 1'b0;
      drop_cnt_q   <= '0;
    end else begin
      state_q      <= state_d;
      bus_pend_q   <= bus_pend_d;
      clr_pend_q   <= clr_pend_d;
      last_grant_q <= last_grant_d;
      lrn_ack_q    <= lrn_ack_d;
      tbl_we_q     <= tbl_we_d;
      tbl_addr_q   <= tbl_addr_d;
      tbl_wdata_q  <= tbl_wdata_d;
      clear_done_q <= clear_done_d;
      drop_cnt_q   <= drop_cnt_d;
    end
  end

  // NOTE: the captured bus key/index carry no reset; they are only consumed
  // while bus_pend_q is set, which is itself reset.
  always_ff @(posedge clk) begin
    bus_flow_q <= bus_flow_d;
    bus_hash_q <= bus_hash_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (clr_pend_q) state_d = CLEAR;
               else if (|grant) state_d = WRITE;
      WRITE:   state_d = IDLE;
      CLEAR:   if (sweep_end) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Registered table-port outputs.
  always_comb begin
    lrn_ack_d    = 1'b0;
    tbl_we_d     = 1'b0;
    clear_done_d = 1'b0;
    tbl_addr_d   = tbl_addr_q;
    tbl_wdata_d  = tbl_wdata_q;
    unique case (state_q)
      IDLE: begin
        if (clr_pend_q) begin
          tbl_we_d    = 1'b1;
          tbl_addr_d  = '0;
          tbl_wdata_d = '0;
        end else if (grant[0]) begin
          tbl_we_d    = 1'b1;
          tbl_addr_d  = bus_hash_q;
          tbl_wdata_d = '{valid: 1'b1, flow: bus_flow_q};
        end else if (grant[1]) begin
          tbl_we_d    = 1'b1;
          lrn_ack_d   = 1'b1;
          tbl_addr_d  = hif.lrn_hash;
          tbl_wdata_d = '{valid: 1'b1, flow: hif.lrn_flow};
        end
      end
      CLEAR: begin
        if (sweep_end) begin
          clear_done_d = 1'b1;
        end else begin
          tbl_we_d   = 1'b1;
          tbl_addr_d = tbl_addr_q + HASH_W'(1);
        end
      end
      default: ;
    endcase
  end

  // Pending flags and drop counter. A bus update is accepted when the slot is
  // free or is being handed to the table at this very edge; otherwise the
  // earlier update keeps the slot and the new one is counted as dropped.
  always_comb begin
    bus_pend_d = bus_pend_q;
    bus_flow_d = bus_flow_q;
    bus_hash_d = bus_hash_q;
    drop_cnt_d = drop_cnt_q;
    clr_pend_d = clr_pend_q;
    if (clr_take || grant[0]) bus_pend_d = 1'b0;
    if (hif.bus_update) begin
      if (!bus_pend_q || grant[0]) begin
        bus_pend_d = 1'b1;
        bus_flow_d = hif.bus_flow;
        bus_hash_d = hif.bus_hash;
      end else if (drop_cnt_q != 8'hFF) begin
        drop_cnt_d = drop_cnt_q + 8'd1;
      end
    end
    if (clr_take) clr_pend_d = 1'b0;
    if (hif.bus_clear && (state_q != CLEAR)) clr_pend_d = 1'b1;
  end

  assign hif.lrn_ack    = lrn_ack_q;
  assign hif.tbl_we     = tbl_we_q;
  assign hif.tbl_addr   = tbl_addr_q;
  assign hif.tbl_wdata  = tbl_wdata_q;
  assign hif.clear_done = clear_done_q;
  assign hif.drop_cnt   = drop_cnt_q;
  assign hif.busy       = (state_q != IDLE) || bus_pend_q || clr_pend_q;

endmodule

// File: tb/tb_tte_hash_ctrl.sv
// Self-checking bench for tte_hash_ctrl: directed scenarios plus a random
// phase, every cycle compared against a transaction-level reference model.
module tb_tte_hash_ctrl;
  import tte_hash_pkg::*;

  logic clk;
  logic rstn;
  int   total = 0;
  int   bad   = 0;

  tte_hash_ctrl_if hif ();

  tte_hash_ctrl dut (
    .clk  (clk),
    .rstn (rstn),
    .hif  (hif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- reference model ----------------
  bit                m_bp;        // bus update waiting for the port
  logic [FLOW_W-1:0] m_bf;
  logic [HASH_W-1:0] m_bh;
  bit                m_clr;       // clear requested, sweep not started
  bit                m_last_lrn;  // learn was the last arbitrated winner
  int                m_sweep;     // address being cleared, -1 when no sweep
  bit                m_gap;       // in the single turnaround cycle after a write
  int                m_drops;
  bit                e_we, e_ack, e_done;
  logic [HASH_W-1:0] e_addr;
  logic [FLOW_W:0]   e_wdata;

  task automatic model_reset();
    m_bp = 0; m_clr = 0; m_last_lrn = 0; m_sweep = -1; m_gap = 0; m_drops = 0;
    e_we = 0; e_ack = 0; e_done = 0; e_addr = '0; e_wdata = '0;
  endtask

  function automatic bit e_busy();
    return (m_sweep >= 0) || m_gap || m_bp || m_clr;
  endfunction

  task automatic model_edge();
    bit in_clear, idle, take_clr, bus_win, lrn_win, old_bp;
    in_clear = (m_sweep >= 0);
    idle     = !in_clear && !m_gap;
    take_clr = idle && m_clr;
    bus_win  = 0;
    lrn_win  = 0;
    if (idle && !m_clr) begin
      if (m_bp && hif.lrn_req) begin
        if (m_last_lrn) bus_win = 1; else lrn_win = 1;
      end else begin
        bus_win = m_bp;
        lrn_win = hif.lrn_req;
      end
    end
    e_ack = 0; e_done = 0; e_we = 0;
    if (take_clr) begin
      m_sweep = 0; e_we = 1; e_addr = '0; e_wdata = '0;
    end else if (bus_win) begin
      e_we = 1; e_addr = m_bh; e_wdata = {1'b1, m_bf}; m_last_lrn = 0; m_gap = 1;
    end else if (lrn_win) begin
      e_we = 1; e_ack = 1; e_addr = hif.lrn_hash; e_wdata = {1'b1, hif.lrn_flow};
      m_last_lrn = 1; m_gap = 1;
    end else if (in_clear) begin
      if (m_sweep == TBL_DEPTH - 1) begin
        m_sweep = -1; e_done = 1;
      end else begin
        m_sweep++; e_we = 1; e_addr = HASH_W'(m_sweep);
      end
    end else begin
      m_gap = 0;
    end
    old_bp = m_bp;
    if (take_clr || bus_win) m_bp = 0;
    if (hif.bus_update) begin
      if (!old_bp || bus_win) begin
        m_bp = 1; m_bf = hif.bus_flow; m_bh = hif.bus_hash;
      end else if (m_drops < 255) begin
        m_drops++;
      end
    end
    if (take_clr) m_clr = 0;
    if (hif.bus_clear && !in_clear) m_clr = 1;
  endtask

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic compare_all();
    check("tbl_we",     128'(hif.tbl_we),     128'(e_we));
    check("tbl_addr",   128'(hif.tbl_addr),   128'(e_addr));
    check("tbl_wdata",  128'(hif.tbl_wdata),  128'(e_wdata));
    check("lrn_ack",    128'(hif.lrn_ack),    128'(e_ack));
    check("clear_done", 128'(hif.clear_done), 128'(e_done));
    check("drop_cnt",   128'(hif.drop_cnt),   128'(m_drops));
    check("busy",       128'(hif.busy),       128'(e_busy()));
  endtask

  // One clock: model follows the edge, outputs compared at the falling edge,
  // pulses end, and the learner drops its request once acknowledged.
  task automatic step();
    @(posedge clk);
    if (!rstn) model_reset(); else model_edge();
    @(negedge clk);
    compare_all();
    hif.bus_update = 1'b0;
    hif.bus_clear  = 1'b0;
    if (e_ack) hif.lrn_req = 1'b0;
  endtask

  function automatic logic [FLOW_W-1:0] rand_flow();
    return FLOW_W'({$urandom(), $urandom(), $urandom(), $urandom()});
  endfunction

  task automatic do_reset();
    rstn = 1'b0;
    hif.lrn_req = 1'b0;
    step();
    step();
    rstn = 1'b1;
    step();
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 50 && (e_busy() || hif.lrn_req); i++) step();
    check("wait_idle_busy", 128'(hif.busy), 128'(0));
  endtask

  task automatic raise_learn(input logic [HASH_W-1:0] h);
    hif.lrn_req  = 1'b1;
    hif.lrn_hash = h;
    hif.lrn_flow = rand_flow();
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [FLOW_W-1:0] a5_flow;
    logic [FLOW_W-1:0] lflow;
    int nwe, offset, done_at, ack_seen, found, ndone;
    bit seq_ok, zero_ok;
    int grants[$];

    rstn = 1'b0;
    hif.bus_update = 0; hif.bus_flow = '0; hif.bus_hash = '0; hif.bus_clear = 0;
    hif.lrn_req = 0; hif.lrn_flow = '0; hif.lrn_hash = '0;
    model_reset();
    repeat (3) step();

    // Reset values.
    check("rst_we",    128'(hif.tbl_we),     128'(0));
    check("rst_addr",  128'(hif.tbl_addr),   128'(0));
    check("rst_wdata", 128'(hif.tbl_wdata),  128'(0));
    check("rst_ack",   128'(hif.lrn_ack),    128'(0));
    check("rst_done",  128'(hif.clear_done), 128'(0));
    check("rst_drop",  128'(hif.drop_cnt),   128'(0));
    check("rst_busy",  128'(hif.busy),       128'(0));
    rstn = 1'b1;
    step();

    // Bus update from idle: write two cycles later, idle again after that.
    a5_flow = {15{8'hA5}};
    hif.bus_update = 1; hif.bus_hash = 10'h155; hif.bus_flow = a5_flow;
    step();
    check("bus_t1_busy", 128'(hif.busy),   128'(1));
    check("bus_t1_we",   128'(hif.tbl_we), 128'(0));
    step();
    check("bus_t2_we",    128'(hif.tbl_we),    128'(1));
    check("bus_t2_addr",  128'(hif.tbl_addr),  128'(10'h155));
    check("bus_t2_wdata", 128'(hif.tbl_wdata), 128'({1'b1, a5_flow}));
    step();
    check("bus_t3_busy", 128'(hif.busy),   128'(0));
    check("bus_t3_we",   128'(hif.tbl_we), 128'(0));

    // Learn from idle: ack and write the next cycle, exactly once.
    raise_learn(10'h3FF);
    lflow = hif.lrn_flow;
    step();
    check("lrn_t1_ack",   128'(hif.lrn_ack),   128'(1));
    check("lrn_t1_we",    128'(hif.tbl_we),    128'(1));
    check("lrn_t1_addr",  128'(hif.tbl_addr),  128'(10'h3FF));
    check("lrn_t1_wdata", 128'(hif.tbl_wdata), 128'({1'b1, lflow}));
    nwe = 0;
    repeat (5) begin
      step();
      if (hif.tbl_we) nwe++;
    end
    check("lrn_single_write", 128'(nwe), 128'(0));

    // Contention: pending bus update and learn request together, 4 rounds.
    for (int r = 0; r < 4; r++) begin
      hif.bus_update = 1; hif.bus_hash = HASH_W'($urandom); hif.bus_flow = rand_flow();
      step();
      raise_learn(HASH_W'($urandom));
      repeat (6) begin
        step();
        if (hif.tbl_we) grants.push_back(hif.lrn_ack ? 1 : 0);
      end
    end
    check("alt_count", 128'(grants.size()), 128'(8));
    foreach (grants[i]) check($sformatf("alt_grant%0d", i), 128'(grants[i]), 128'(i % 2));

    // Random traffic against the model.
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 2) == 0) begin
        hif.bus_update = 1; hif.bus_hash = HASH_W'($urandom); hif.bus_flow = rand_flow();
      end
      if (!hif.lrn_req && $urandom_range(0, 3) == 0) raise_learn(HASH_W'($urandom));
      step();
    end
    wait_idle();
    do_reset();

    // Clear sweep with learn held and three bus pulses at its start.
    hif.bus_clear = 1;
    step();
    offset = 1; nwe = 0; seq_ok = 1; zero_ok = 1; done_at = -1; ack_seen = 0;
    raise_learn(10'h2A5);
    hif.bus_update = 1; hif.bus_hash = 10'h0F0; hif.bus_flow = rand_flow();
    for (int i = 0; i < 1100 && done_at < 0; i++) begin
      step();
      offset++;
      if (offset <= 3) begin
        hif.bus_update = 1; hif.bus_hash = HASH_W'($urandom); hif.bus_flow = rand_flow();
      end
      if (hif.lrn_ack) ack_seen++;
      if (hif.tbl_we) begin
        if (hif.tbl_addr !== HASH_W'(nwe)) seq_ok = 0;
        if (hif.tbl_wdata !== '0) zero_ok = 0;
        nwe++;
      end
      if (hif.clear_done) done_at = offset;
    end
    check("clr_done_cycle", 128'(done_at),  128'(1026));
    check("clr_writes",     128'(nwe),      128'(TBL_DEPTH));
    check("clr_addr_seq",   128'(seq_ok),   128'(1));
    check("clr_data_zero",  128'(zero_ok),  128'(1));
    check("clr_no_ack",     128'(ack_seen), 128'(0));
    check("clr_drop2",      128'(hif.drop_cnt), 128'(2));
    for (int i = 0; i < 10 && ack_seen == 0; i++) begin
      step();
      if (hif.lrn_ack) ack_seen++;
    end
    check("clr_ack_after", 128'(ack_seen), 128'(1));
    wait_idle();

    // Drop counter saturation: 300 pulses while a sweep owns the port.
    hif.bus_clear = 1;
    step();
    for (int i = 0; i < 300; i++) begin
      hif.bus_update = 1; hif.bus_hash = HASH_W'($urandom); hif.bus_flow = rand_flow();
      step();
    end
    check("drop_sat", 128'(hif.drop_cnt), 128'(255));
    ndone = 0;
    for (int i = 0; i < 1100 && ndone == 0; i++) begin
      step();
      if (hif.clear_done) ndone++;
    end
    check("sat_sweep_done", 128'(ndone), 128'(1));
    wait_idle();

    // Reset in the middle of a sweep.
    hif.bus_clear = 1;
    step();
    found = 0;
    for (int i = 0; i < 200 && found == 0; i++) begin
      step();
      if (hif.tbl_we && hif.tbl_addr == 10'h080) found = 1;
    end
    check("mid_found", 128'(found), 128'(1));
    rstn = 1'b0;
    #1;
    check("mid_rst_we",    128'(hif.tbl_we),     128'(0));
    check("mid_rst_addr",  128'(hif.tbl_addr),   128'(0));
    check("mid_rst_wdata", 128'(hif.tbl_wdata),  128'(0));
    check("mid_rst_done",  128'(hif.clear_done), 128'(0));
    check("mid_rst_drop",  128'(hif.drop_cnt),   128'(0));
    check("mid_rst_busy",  128'(hif.busy),       128'(0));
    model_reset();
    step();
    rstn = 1'b1;
    ndone = 0;
    repeat (1100) begin
      step();
      if (hif.clear_done) ndone++;
    end
    check("mid_no_done", 128'(ndone), 128'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
